// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - two-requester register-file write arbiter with pending-write scoreboard
//
// Purpose: arbitrates ALU (req0) and load (req1) writebacks onto a single
// register-file write port with round-robin priority, and tracks which
// registers have an in-flight write so the issue stage can stall on them.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/reg/data, req0_ready ALU writeback requester
//   req1_valid/reg/data, req1_ready load writeback requester
//   write_reg, write_data           registered write port address/data
//   signal_reg_write                one-cycle write strobe (never for reg 0)
//   mark_valid, mark_reg            issue stage marks a destination pending
//   read_reg_1/2, busy_1/2          pending status of source registers
//   flush                           blocks grants and clears the scoreboard
module regfile_write_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              signal_reg_write,
    input  logic              mark_valid,
    input  logic [ADDR_W-1:0] mark_reg,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              flush
);

    localparam int NREG = 1 << ADDR_W;

    // r_ptr names the requester that wins a tie: 0 = req0, 1 = req1.
    logic              r_ptr;
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_write_en;

    logic              w_grant0;
    logic              w_grant1;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_win_reg;
    logic [DATA_W-1:0] w_win_data;
    logic [NREG-1:0]   w_busy_nxt;

    // Grants are qualified by valid, so a grant is always a transfer.
    // rst_n gates the grants so ready stays low for the whole reset window.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (rst_n && !flush) begin
            if (req0_valid && req1_valid) begin
                w_grant0 = ~r_ptr;
                w_grant1 = r_ptr;
            end else begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign w_xfer     = w_grant0 | w_grant1;
    assign w_win_reg  = w_grant1 ? req1_reg  : req0_reg;
    assign w_win_data = w_grant1 ? req1_data : req0_data;

    // Clear for the committed write is applied before the set so that a
    // new mark of the same register in the same cycle leaves it pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_xfer && (w_win_reg != '0)) begin
                w_busy_nxt[w_win_reg] = 1'b0;
            end
            if (mark_valid && (mark_reg != '0)) begin
                w_busy_nxt[mark_reg] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= 1'b0;
            r_busy       <= '0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_xfer) begin
                // Hand priority to whichever requester did not win.
                r_ptr        <= w_grant0;
                r_write_reg  <= w_win_reg;
                r_write_data <= w_win_data;
                r_write_en   <= (w_win_reg != '0);
            end else begin
                r_write_en   <= 1'b0;
            end
        end
    end

    assign write_reg        = r_write_reg;
    assign write_data       = r_write_data;
    assign signal_reg_write = r_write_en;

    // Register 0 is hardwired zero, so it is never reported pending.
    assign busy_1 = (read_reg_1 != '0) && r_busy[read_reg_1];
    assign busy_2 = (read_reg_2 != '0) && r_busy[read_reg_2];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - self-checking bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_reg, req1_reg;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        signal_reg_write;
    logic        mark_valid;
    logic [4:0]  mark_reg;
    logic [4:0]  read_reg_1, read_reg_2;
    logic        busy_1, busy_2;
    logic        flush;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_write_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_reg(write_reg), .write_data(write_data), .signal_reg_write(signal_reg_write),
        .mark_valid(mark_valid), .mark_reg(mark_reg),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .busy_1(busy_1), .busy_2(busy_2),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as it stands after the most recent rising edge.
    bit          m_busy [32];
    int          m_ptr;
    bit          m_wen;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_ptr   = 0;
        m_wen   = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
    endtask

    // Inputs change only just after rising edges, so the values seen at the
    // falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        int          win;
        logic [4:0]  wr;
        logic [31:0] wd;
        if (!rst_n) begin
            model_reset();
            chk("rst_req0_ready", 64'(req0_ready), 64'(0));
            chk("rst_req1_ready", 64'(req1_ready), 64'(0));
            chk("rst_write_en", 64'(signal_reg_write), 64'(0));
            chk("rst_write_reg", 64'(write_reg), 64'(0));
            chk("rst_write_data", 64'(write_data), 64'(0));
            chk("rst_busy_1", 64'(busy_1), 64'(0));
            chk("rst_busy_2", 64'(busy_2), 64'(0));
        end else begin
            win = -1;
            if (!flush) begin
                if (req0_valid && req1_valid) win = m_ptr;
                else if (req0_valid)          win = 0;
                else if (req1_valid)          win = 1;
            end
            chk("m_req0_ready", 64'(req0_ready), 64'(win == 0));
            chk("m_req1_ready", 64'(req1_ready), 64'(win == 1));
            chk("m_busy_1", 64'(busy_1), 64'(read_reg_1 != 0 && m_busy[read_reg_1]));
            chk("m_busy_2", 64'(busy_2), 64'(read_reg_2 != 0 && m_busy[read_reg_2]));
            chk("m_write_en", 64'(signal_reg_write), 64'(m_wen));
            chk("m_write_reg", 64'(write_reg), 64'(m_wreg));
            chk("m_write_data", 64'(write_data), 64'(m_wdata));

            wr = '0;
            if (win >= 0) begin
                wr      = (win == 0) ? req0_reg  : req1_reg;
                wd      = (win == 0) ? req0_data : req1_data;
                m_ptr   = 1 - win;
                m_wen   = (wr != 0);
                m_wreg  = wr;
                m_wdata = wd;
            end else begin
                m_wen = 1'b0;
            end
            if (flush) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
            end else begin
                if (win >= 0 && wr != 0) m_busy[wr] = 1'b0;
                if (mark_valid && mark_reg != 0) m_busy[mark_reg] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; mark_valid = 0; flush = 0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; mark_valid = 0; flush = 0;
        req0_reg = 0; req1_reg = 0; req0_data = 0; req1_data = 0;
        mark_reg = 0; read_reg_1 = 0; read_reg_2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_write_en", 64'(signal_reg_write), 64'(0));
        chk("reset_write_reg", 64'(write_reg), 64'(0));
        rst_n = 1'b1;
        tick();

        // Single request to reg 2.
        req0_valid = 1; req0_reg = 5'd2; req0_data = 32'hFAAAAAAA;
        @(negedge clk);
        chk("single_ready", 64'(req0_ready), 64'(1));
        tick(); idle_inputs();
        @(negedge clk);
        chk("single_wen", 64'(signal_reg_write), 64'(1));
        chk("single_wreg", 64'(write_reg), 64'(2));
        chk("single_wdata", 64'(write_data), 64'(32'hFAAAAAAA));
        tick();
        @(negedge clk);
        chk("single_wen_drop", 64'(signal_reg_write), 64'(0));

        // Contention straight after reset: req0, req1, req0, req1.
        tick();
        pulse_reset();
        req0_valid = 1; req0_reg = 5'd3; req0_data = 32'h33;
        req1_valid = 1; req1_reg = 5'd4; req1_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", 64'(req0_ready), 64'(i % 2 == 0));
            chk("rr_ready1", 64'(req1_ready), 64'(i % 2 == 1));
            if (i > 0) chk("rr_wreg", 64'(write_reg), 64'((i % 2 == 1) ? 3 : 4));
            tick();
        end
        idle_inputs();
        @(negedge clk);
        chk("rr_wreg_last", 64'(write_reg), 64'(4));
        tick();

        // Scoreboard on reg 14; read_reg_2 stays 0.
        mark_valid = 1; mark_reg = 5'd14; read_reg_1 = 5'd14; read_reg_2 = 5'd0;
        tick(); mark_valid = 0;
        @(negedge clk);
        chk("sb_busy1_set", 64'(busy_1), 64'(1));
        chk("sb_busy2_zero", 64'(busy_2), 64'(0));
        tick();
        req1_valid = 1; req1_reg = 5'd14; req1_data = 32'hE;
        @(negedge clk);
        chk("sb_ready1", 64'(req1_ready), 64'(1));
        chk("sb_busy1_before", 64'(busy_1), 64'(1));
        tick(); idle_inputs();
        @(negedge clk);
        chk("sb_busy1_clear", 64'(busy_1), 64'(0));
        chk("sb_busy2_still0", 64'(busy_2), 64'(0));
        chk("sb_wreg", 64'(write_reg), 64'(14));
        tick();

        // Simultaneous set and clear on reg 8.
        read_reg_1 = 5'd8;
        mark_valid = 1; mark_reg = 5'd8;
        req0_valid = 1; req0_reg = 5'd8; req0_data = 32'h8888;
        @(negedge clk);
        chk("sim_ready0", 64'(req0_ready), 64'(1));
        tick(); idle_inputs();
        @(negedge clk);
        chk("sim_busy8", 64'(busy_1), 64'(1));
        chk("sim_wen", 64'(signal_reg_write), 64'(1));
        chk("sim_wreg", 64'(write_reg), 64'(8));
        tick();

        // Register 0 transfer.
        req0_valid = 1; req0_reg = 5'd0; req0_data = 32'h1234;
        @(negedge clk);
        chk("r0_ready", 64'(req0_ready), 64'(1));
        tick(); idle_inputs();
        @(negedge clk);
        chk("r0_wen", 64'(signal_reg_write), 64'(0));
        tick();

        // Flush with regs 5 and 9 busy; the write before the flush survives.
        mark_valid = 1; mark_reg = 5'd5; tick();
        mark_reg = 5'd9;
        req0_valid = 1; req0_reg = 5'd11; req0_data = 32'hB;
        tick(); idle_inputs();
        read_reg_1 = 5'd5; read_reg_2 = 5'd9;
        flush = 1; mark_valid = 1; mark_reg = 5'd10;
        req0_valid = 1; req0_reg = 5'd6; req1_valid = 1; req1_reg = 5'd7;
        @(negedge clk);
        chk("fl_busy5", 64'(busy_1), 64'(1));
        chk("fl_busy9", 64'(busy_2), 64'(1));
        chk("fl_ready0", 64'(req0_ready), 64'(0));
        chk("fl_ready1", 64'(req1_ready), 64'(0));
        chk("fl_prior_wen", 64'(signal_reg_write), 64'(1));
        chk("fl_prior_wreg", 64'(write_reg), 64'(11));
        tick(); idle_inputs();
        @(negedge clk);
        chk("fl_busy5_clr", 64'(busy_1), 64'(0));
        chk("fl_busy9_clr", 64'(busy_2), 64'(0));
        chk("fl_wen", 64'(signal_reg_write), 64'(0));
        read_reg_1 = 5'd10;
        #1;
        chk("fl_mark_overridden", 64'(busy_1), 64'(0));
        tick();

        // Asynchronous reset the cycle after a transfer; req1 holds priority beforehand.
        mark_valid = 1; mark_reg = 5'd12; read_reg_1 = 5'd12;
        req1_valid = 1; req1_reg = 5'd13; req1_data = 32'hD;
        tick(); idle_inputs();
        req0_valid = 1; req0_reg = 5'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wen", 64'(signal_reg_write), 64'(0));
        chk("ar_wreg", 64'(write_reg), 64'(0));
        chk("ar_busy1", 64'(busy_1), 64'(0));
        chk("ar_ready0", 64'(req0_ready), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        req1_valid = 1; req1_reg = 5'd2;
        @(negedge clk);
        chk("ar_first_ready0", 64'(req0_ready), 64'(1));
        chk("ar_first_ready1", 64'(req1_ready), 64'(0));
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_reg   = 5'($urandom_range(0, 31));
            req1_reg   = 5'($urandom_range(0, 31));
            req0_data  = $urandom;
            req1_data  = $urandom;
            mark_valid = ($urandom_range(0, 1) != 0);
            mark_reg   = 5'($urandom_range(0, 31));
            read_reg_1 = 5'($urandom_range(0, 31));
            read_reg_2 = 5'($urandom_range(0, 31));
            flush      = ($urandom_range(0, 19) == 0);
            if (c == 1500) pulse_reset();
            tick();
        end
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
